// File: rtl/fp2i_pkg.sv
// Shared constants, operand classes and the classify helper for the FP32-to-integer converter.
package fp2i_pkg;

    localparam logic [1:0] RNE = 2'b00;
    localparam logic [1:0] RTZ = 2'b01;
    localparam logic [1:0] RUP = 2'b10;
    localparam logic [1:0] RDN = 2'b11;

    localparam int EXP_BIAS = 127;
    localparam int MANT_W   = 23;
    localparam int EXP_W    = 8;

    typedef enum logic [2:0] {
        ZERO   = 3'd0,
        DENORM = 3'd1,
        NORMAL = 3'd2,
        INF    = 3'd3,
        NAN    = 3'd4
    } cls_t;

    function automatic cls_t classify(input logic [EXP_W-1:0] exp_f, input logic [MANT_W-1:0] frac_f);
        cls_t c;
        if (exp_f == 8'hFF) begin
            c = (frac_f != 23'd0) ? NAN : INF;
        end else if (exp_f == 8'h00) begin
            c = (frac_f != 23'd0) ? DENORM : ZERO;
        end else begin
            c = NORMAL;
        end
        return c;
    endfunction

endpackage

// File: rtl/fp2i_round_sat.sv
// Final conversion stage: rounding increment, range check against the signed/unsigned limits,
// saturation of specials and out-of-range values, and negation.
module fp2i_round_sat
    import fp2i_pkg::*;
#(
    parameter int INT_W = 32
) (
    input  logic [INT_W-1:0] mag,
    input  logic             guard,
    input  logic             sticky,
    input  logic             sign,
    input  logic [1:0]       mode,
    input  logic             is_signed,
    input  logic             pre_ovf,
    input  logic [2:0]       cls,
    output logic [INT_W-1:0] result,
    output logic             invalid,
    output logic             inexact
);

    localparam logic [INT_W-1:0] UMAX = {INT_W{1'b1}};
    localparam logic [INT_W-1:0] SMAX = {1'b0, {(INT_W-1){1'b1}}};
    localparam logic [INT_W-1:0] SMIN = {1'b1, {(INT_W-1){1'b0}}};

    logic             rnd_up_s;
    logic [INT_W:0]   sum_s;
    logic             ovf_s;
    logic [INT_W-1:0] pos_lim_s;
    logic [INT_W-1:0] neg_lim_s;

    // Rounding decision, magnitude increment and range check.
    always_comb begin
        rnd_up_s = 1'b0;
        case (mode)
            RNE:     rnd_up_s = guard & (sticky | mag[0]);
            RTZ:     rnd_up_s = 1'b0;
            RUP:     rnd_up_s = ~sign & (guard | sticky);
            RDN:     rnd_up_s = sign & (guard | sticky);
            default: rnd_up_s = 1'b0;
        endcase
        sum_s     = {1'b0, mag} + {{INT_W{1'b0}}, rnd_up_s};
        pos_lim_s = is_signed ? SMAX : UMAX;
        neg_lim_s = is_signed ? SMIN : {INT_W{1'b0}};
        ovf_s     = 1'b0;
        if (pre_ovf) begin
            ovf_s = 1'b1;
        end else if (is_signed) begin
            // A negative magnitude of exactly 2^(INT_W-1) is the legal minimum.
            ovf_s = sign ? (sum_s[INT_W] | (sum_s[INT_W-1] & (|sum_s[INT_W-2:0])))
                         : (sum_s[INT_W] | sum_s[INT_W-1]);
        end else begin
            ovf_s = sign ? (sum_s != {(INT_W+1){1'b0}}) : sum_s[INT_W];
        end
    end

    // Result selection: specials and overflow saturate, everything else is the rounded value.
    always_comb begin
        result  = {INT_W{1'b0}};
        invalid = 1'b0;
        inexact = 1'b0;
        if (cls == NAN) begin
            result  = pos_lim_s;
            invalid = 1'b1;
        end else if (cls == INF) begin
            result  = sign ? neg_lim_s : pos_lim_s;
            invalid = 1'b1;
        end else if (ovf_s) begin
            result  = sign ? neg_lim_s : pos_lim_s;
            invalid = 1'b1;
        end else begin
            result  = sign ? (-sum_s[INT_W-1:0]) : sum_s[INT_W-1:0];
            inexact = guard | sticky;
        end
    end

endmodule

// File: rtl/fp32_to_int_pipe.sv
// Three-stage FP32 to integer converter with a global-stall valid/ready pipeline.
// Define FP2I_PERF_CNT_EN to build the conversion and exception counters.
module fp32_to_int_pipe
    import fp2i_pkg::*;
#(
    parameter int INT_W     = 32,
    parameter int RST_FLAGS = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      a_operand,
    input  logic [1:0]       rnd_mode,
    input  logic             is_signed,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [INT_W-1:0] int_result,
    output logic             flag_invalid,
    output logic             flag_inexact,
    output logic [15:0]      conv_count,
    output logic [15:0]      exc_count
);

    localparam int EW = ((INT_W > 24) ? INT_W : 24) + 25;
    localparam logic signed [9:0] INT_W_E = 10'(INT_W);

    logic                     advance_s;
    logic [EXP_W-1:0]         exp_s;
    logic [MANT_W-1:0]        frac_s;
    cls_t                     cls_s;
    logic signed [9:0]        e_s;

    logic                     v1_r, sign1_r, signed1_r;
    logic signed [9:0]        e1_r;
    logic [MANT_W:0]          mant1_r;
    logic [1:0]               mode1_r;
    cls_t                     cls1_r;

    logic [EW-1:0]            base_s, ext_s;
    logic [INT_W-1:0]         mag_s;
    logic                     g_s, st_s, povf_s;

    logic                     v2_r, sign2_r, signed2_r, g2_r, st2_r, povf2_r;
    logic [INT_W-1:0]         mag2_r;
    logic [1:0]               mode2_r;
    cls_t                     cls2_r;

    logic [INT_W-1:0]         res_s;
    logic                     inv_s, inx_s;

    logic                     out_valid_r, flag_inv_r, flag_inx_r;
    logic [INT_W-1:0]         int_result_r;

    assign advance_s  = ~out_valid_r | out_ready;
    assign in_ready   = advance_s;
    assign out_valid  = out_valid_r;
    assign int_result = int_result_r;
    assign flag_invalid = flag_inv_r;
    assign flag_inexact = flag_inx_r;

    // Field extraction and operand classification.
    always_comb begin
        exp_s  = a_operand[30:23];
        frac_s = a_operand[22:0];
        cls_s  = classify(exp_s, frac_s);
        e_s    = $signed({2'b00, exp_s}) - 10'(EXP_BIAS);
    end

    // S1: latch sign, unbiased exponent, mantissa with hidden bit, mode and class.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1_r      <= 1'b0;
            sign1_r   <= 1'b0;
            signed1_r <= 1'b0;
            e1_r      <= 10'sd0;
            mant1_r   <= 24'd0;
            mode1_r   <= 2'b00;
            cls1_r    <= ZERO;
        end else if (advance_s) begin
            v1_r      <= in_valid;
            sign1_r   <= a_operand[31];
            signed1_r <= is_signed;
            e1_r      <= e_s;
            mant1_r   <= {(exp_s != 8'h00), frac_s};
            mode1_r   <= rnd_mode;
            cls1_r    <= cls_s;
        end
    end

    // Alignment: the binary point sits between bits 25 and 24 of ext_s, bit 24 is the guard.
    always_comb begin
        base_s = EW'({mant1_r, 25'd0});
        ext_s  = {EW{1'b0}};
        mag_s  = {INT_W{1'b0}};
        g_s    = 1'b0;
        st_s   = 1'b0;
        povf_s = (e1_r >= INT_W_E);
        if (e1_r < -10'sd1) begin
            st_s = |mant1_r;
        end else begin
            if (e1_r > 10'sd23) begin
                ext_s = base_s << (e1_r - 10'sd23);
            end else begin
                ext_s = base_s >> (10'sd23 - e1_r);
            end
            mag_s = INT_W'(ext_s[EW-1:25]);
            g_s   = ext_s[24];
            st_s  = |ext_s[23:0];
        end
    end

    // S2: latch the aligned magnitude with guard, sticky and pre-overflow.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v2_r      <= 1'b0;
            sign2_r   <= 1'b0;
            signed2_r <= 1'b0;
            g2_r      <= 1'b0;
            st2_r     <= 1'b0;
            povf2_r   <= 1'b0;
            mag2_r    <= {INT_W{1'b0}};
            mode2_r   <= 2'b00;
            cls2_r    <= ZERO;
        end else if (advance_s) begin
            v2_r      <= v1_r;
            sign2_r   <= sign1_r;
            signed2_r <= signed1_r;
            g2_r      <= g_s;
            st2_r     <= st_s;
            povf2_r   <= povf_s;
            mag2_r    <= mag_s;
            mode2_r   <= mode1_r;
            cls2_r    <= cls1_r;
        end
    end

    fp2i_round_sat #(.INT_W(INT_W)) u_round_sat (
        .mag       (mag2_r),
        .guard     (g2_r),
        .sticky    (st2_r),
        .sign      (sign2_r),
        .mode      (mode2_r),
        .is_signed (signed2_r),
        .pre_ovf   (povf2_r),
        .cls       (cls2_r),
        .result    (res_s),
        .invalid   (inv_s),
        .inexact   (inx_s)
    );

    // S3 output register; flags are cleared in reset only when RST_FLAGS is set.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_r  <= 1'b0;
            int_result_r <= {INT_W{1'b0}};
            if (RST_FLAGS != 0) begin
                flag_inv_r <= 1'b0;
                flag_inx_r <= 1'b0;
            end
        end else if (advance_s) begin
            out_valid_r  <= v2_r;
            int_result_r <= res_s;
            flag_inv_r   <= inv_s;
            flag_inx_r   <= inx_s;
        end
    end

`ifdef FP2I_PERF_CNT_EN
    logic [15:0] conv_cnt_r, exc_cnt_r;

    // Saturating counters of accepted operands and of delivered invalid results.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            conv_cnt_r <= 16'h0000;
            exc_cnt_r  <= 16'h0000;
        end else begin
            if (in_valid && advance_s && (conv_cnt_r != 16'hFFFF)) begin
                conv_cnt_r <= conv_cnt_r + 16'd1;
            end
            if (out_valid_r && out_ready && flag_inv_r && (exc_cnt_r != 16'hFFFF)) begin
                exc_cnt_r <= exc_cnt_r + 16'd1;
            end
        end
    end

    assign conv_count = conv_cnt_r;
    assign exc_count  = exc_cnt_r;
`else
    assign conv_count = 16'h0000;
    assign exc_count  = 16'h0000;
`endif

endmodule

// File: tb/tb_fp32_to_int_pipe.sv
// Directed bench for fp32_to_int_pipe: a 32-bit and an 8-bit instance share one stimulus stream.
module tb_fp32_to_int_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic        is_signed = 1'b1;
    logic [31:0] a_operand = 32'h0;
    logic [1:0]  rnd_mode = 2'b00;

    logic        in_ready32, out_valid32, inv32, inx32;
    logic [31:0] res32;
    logic [15:0] cc32, ec32;
    logic        in_ready8, out_valid8, inv8, inx8;
    logic [7:0]  res8;
    logic [15:0] cc8, ec8;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] ops [6];

    always #5 clk = ~clk;

    fp32_to_int_pipe #(.INT_W(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready32),
        .a_operand(a_operand), .rnd_mode(rnd_mode), .is_signed(is_signed),
        .out_valid(out_valid32), .out_ready(out_ready), .int_result(res32),
        .flag_invalid(inv32), .flag_inexact(inx32), .conv_count(cc32), .exc_count(ec32)
    );

    fp32_to_int_pipe #(.INT_W(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready8),
        .a_operand(a_operand), .rnd_mode(rnd_mode), .is_signed(is_signed),
        .out_valid(out_valid8), .out_ready(out_ready), .int_result(res8),
        .flag_invalid(inv8), .flag_inexact(inx8), .conv_count(cc8), .exc_count(ec8)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One isolated conversion: drive for one cycle, wait for the result, check latency/value/flags.
    task automatic conv(input string tag, input logic [31:0] a, input logic [1:0] m, input logic sgn,
                        input bit use8, input logic [31:0] exp_res, input logic exp_inv, input logic exp_inx);
        int   lat;
        logic ov;
        @(posedge clk); #1;
        a_operand = a;
        rnd_mode  = m;
        is_signed = sgn;
        in_valid  = 1'b1;
        lat = 0;
        ov  = 1'b0;
        for (int k = 1; k <= 8 && !ov; k++) begin
            @(posedge clk); #1;
            if (k == 1) in_valid = 1'b0;
            ov  = use8 ? out_valid8 : out_valid32;
            lat = k;
        end
        check({tag, " valid"}, {31'd0, ov}, 32'd1);
        check({tag, " latency"}, lat, 32'd3);
        check({tag, " result"}, use8 ? {24'd0, res8} : res32, exp_res);
        check({tag, " flags"}, use8 ? {30'd0, inv8, inx8} : {30'd0, inv32, inx32},
              {30'd0, exp_inv, exp_inx});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   idx, rcv, stale;
        logic acc, prev_stall, ir_low;
        logic [31:0] held;

        ops[0] = 32'h3F800000; ops[1] = 32'h40000000; ops[2] = 32'h40400000;
        ops[3] = 32'h40800000; ops[4] = 32'h40A00000; ops[5] = 32'h40C00000;

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        check("rst out_valid", {31'd0, out_valid32}, 32'd0);
        check("rst result", res32, 32'd0);
        check("rst flags", {30'd0, inv32, inx32}, 32'd0);
        check("rst in_ready", {31'd0, in_ready32}, 32'd1);
        check("rst counters", {cc32, ec32}, 32'd0);
        check("rst8 state", {22'd0, in_ready8, out_valid8, res8}, {22'd0, 1'b1, 1'b0, 8'h00});
        check("rst8 counters", {cc8, ec8}, 32'd0);

        conv("3.5 rne",   32'h40600000, 2'b00, 1'b1, 1'b0, 32'd4,        1'b0, 1'b1);
        conv("3.5 rtz",   32'h40600000, 2'b01, 1'b1, 1'b0, 32'd3,        1'b0, 1'b1);
        conv("3.5 rdn",   32'h40600000, 2'b11, 1'b1, 1'b0, 32'd3,        1'b0, 1'b1);
        conv("3.5 rup",   32'h40600000, 2'b10, 1'b1, 1'b0, 32'd4,        1'b0, 1'b1);
        conv("-2.5 rne",  32'hC0200000, 2'b00, 1'b1, 1'b0, 32'hFFFFFFFE, 1'b0, 1'b1);
        conv("-2.5 rdn",  32'hC0200000, 2'b11, 1'b1, 1'b0, 32'hFFFFFFFD, 1'b0, 1'b1);
        conv("-2^31",     32'hCF000000, 2'b00, 1'b1, 1'b0, 32'h80000000, 1'b0, 1'b0);
        conv("2^31",      32'h4F000000, 2'b00, 1'b1, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b0);
        conv("nan",       32'h7FC00000, 2'b00, 1'b1, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b0);
        conv("+inf",      32'h7F800000, 2'b00, 1'b1, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b0);
        conv("-inf",      32'hFF800000, 2'b00, 1'b1, 1'b0, 32'h80000000, 1'b1, 1'b0);
        conv("-0",        32'h80000000, 2'b00, 1'b1, 1'b0, 32'd0,        1'b0, 1'b0);
        conv("0.5 rne",   32'h3F000000, 2'b00, 1'b1, 1'b0, 32'd0,        1'b0, 1'b1);
        conv("0.5 rup",   32'h3F000000, 2'b10, 1'b1, 1'b0, 32'd1,        1'b0, 1'b1);
        conv("2^24+2",    32'h4B800001, 2'b01, 1'b1, 1'b0, 32'h01000002, 1'b0, 1'b0);
        conv("u8 255",    32'h437F0000, 2'b00, 1'b0, 1'b1, 32'h000000FF, 1'b0, 1'b0);
        conv("u8 256",    32'h43800000, 2'b00, 1'b0, 1'b1, 32'h000000FF, 1'b1, 1'b0);
        conv("u8 -1.0",   32'hBF800000, 2'b00, 1'b0, 1'b1, 32'h00000000, 1'b1, 1'b0);
        conv("u8 -0.3",   32'hBE99999A, 2'b01, 1'b0, 1'b1, 32'h00000000, 1'b0, 1'b1);

        repeat (2) @(posedge clk);
        #1;
`ifdef FP2I_PERF_CNT_EN
        check("directed conv_count", {16'd0, cc32}, 32'd19);
        check("directed exc_count", {16'd0, ec32}, 32'd5);
`else
        check("directed counters tied", {cc32, ec32}, 32'd0);
`endif

        // Reset with three operands in flight.
        @(posedge clk); #1;
        in_valid = 1'b1; is_signed = 1'b1; rnd_mode = 2'b01; a_operand = 32'h3F800000;
        @(posedge clk); #1 a_operand = 32'h40000000;
        @(posedge clk); #1 a_operand = 32'h40400000;
        @(posedge clk); #1 in_valid = 1'b0; rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        check("midrst out_valid", {31'd0, out_valid32}, 32'd0);
        check("midrst counters", {cc32, ec32}, 32'd0);
        stale = 0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid32 || out_valid8) stale++;
        end
        check("midrst stale results", stale, 32'd0);

        // Back-to-back stream of 1.0..6.0 with the sink stalled for cycles 4..9.
        idx = 0; rcv = 0; acc = 1'b0; prev_stall = 1'b0; ir_low = 1'b0; held = 32'd0;
        rnd_mode = 2'b01; is_signed = 1'b1;
        for (int cyc = 0; cyc < 30; cyc++) begin
            @(posedge clk); #1;
            if (acc) idx++;
            in_valid  = (idx < 6);
            a_operand = (idx < 6) ? ops[idx] : 32'h0;
            out_ready = !(cyc >= 4 && cyc <= 9);
            @(negedge clk);
            acc = in_valid && in_ready32;
            if (!in_ready32) ir_low = 1'b1;
            if (prev_stall) begin
                check("bp hold valid", {31'd0, out_valid32}, 32'd1);
                check("bp hold result", res32, held);
            end
            prev_stall = out_valid32 && !out_ready;
            held = res32;
            if (out_valid32 && out_ready) begin
                check("bp order", res32, rcv + 1);
                rcv++;
            end
        end
        check("bp result count", rcv, 32'd6);
        check("bp in_ready dropped", {31'd0, ir_low}, 32'd1);
`ifdef FP2I_PERF_CNT_EN
        check("bp conv_count", {16'd0, cc32}, 32'd6);
        check("bp exc_count", {16'd0, ec32}, 32'd0);
`else
        check("bp counters tied", {cc32, ec32}, 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
